store_commit_buffer: RTL and testbench

- Post-issue store buffer between the LSQ and the data cache. The LSQ pushes each store's address, data and byte enables once they are resolved.
- The ROB retire pulse (rob_ret_store) marks the oldest uncommitted entry committed. Only committed entries drain to the dcache, in program order.
- rob_flush discards uncommitted entries.
- Younger loads probe the buffer for store-to-load forwarding.

---
 rtl/store_commit_buffer.sv | 123 ++++++++++++
 tb/tb_store_commit_buffer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_commit_buffer.sv
// Post-issue store buffer: LSQ pushes resolved stores, ROB retirement commits them in order,
// committed entries drain to the dcache, and younger loads probe it for forwarding.
module store_commit_buffer #(
    parameter int DEPTH = 16,
    parameter int IDXW  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsq_sb_valid,
    input  logic [29:0] lsq_sb_addr,
    input  logic [31:0] lsq_sb_data,
    input  logic [3:0]  lsq_sb_be,
    output logic        sb_full,
    input  logic        rob_ret_store,
    input  logic        rob_flush,
    output logic        sb_dc_req,
    output logic [29:0] sb_dc_addr,
    output logic [31:0] sb_dc_data,
    output logic [3:0]  sb_dc_be,
    input  logic        dc_sb_ack,
    input  logic        ld_valid,
    input  logic [29:0] ld_addr,
    input  logic [3:0]  ld_be,
    output logic        sb_ld_hit,
    output logic [31:0] sb_ld_data,
    output logic        sb_ld_conflict,
    output logic        sb_empty
);
    // Pointers carry a polarity bit above the index so full and empty are distinguishable.
    typedef logic [IDXW:0] ptr_t;

    logic [29:0] r_addr [DEPTH];
    logic [31:0] r_data [DEPTH];
    logic [3:0]  r_be   [DEPTH];

    ptr_t r_head;
    ptr_t r_cmt;
    ptr_t r_tail;

    logic            w_full;
    logic            w_push;
    logic            w_commit;
    logic            w_ack;
    logic            w_req;
    ptr_t            w_cmt_nxt;
    ptr_t            w_count;
    logic [IDXW-1:0] w_head_idx;
    logic [IDXW-1:0] w_tail_idx;

    assign w_head_idx = r_head[IDXW-1:0];
    assign w_tail_idx = r_tail[IDXW-1:0];
    assign w_count    = r_tail - r_head;

    assign w_full   = (w_head_idx == w_tail_idx) && (r_head[IDXW] != r_tail[IDXW]);
    assign w_req    = (r_head != r_cmt);
    assign w_push   = lsq_sb_valid & ~w_full & ~rob_flush;
    assign w_commit = rob_ret_store & (r_cmt != r_tail);
    // Drain handshake: sb_dc_req holds entry[head] steady until a cycle with dc_sb_ack;
    // that cycle transfers the entry. An ack while req is low does nothing.
    assign w_ack     = dc_sb_ack & w_req;
    assign w_cmt_nxt = w_commit ? r_cmt + ptr_t'(1) : r_cmt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_cmt  <= '0;
            r_tail <= '0;
        end else begin
            if (w_ack) begin
                r_head <= r_head + ptr_t'(1);
            end
            r_cmt <= w_cmt_nxt;
            if (rob_flush) begin
                r_tail <= w_cmt_nxt;
            end else if (w_push) begin
                r_tail <= r_tail + ptr_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[w_tail_idx] <= lsq_sb_addr;
            r_data[w_tail_idx] <= lsq_sb_data;
            r_be[w_tail_idx]   <= lsq_sb_be;
        end
    end

    assign sb_full    = w_full;
    assign sb_empty   = (r_head == r_tail);
    assign sb_dc_req  = w_req;
    assign sb_dc_addr = r_addr[w_head_idx];
    assign sb_dc_data = r_data[w_head_idx];
    assign sb_dc_be   = r_be[w_head_idx];

    logic            w_fwd_found;
    logic [31:0]     w_fwd_data;
    logic [3:0]      w_fwd_be;
    logic [IDXW-1:0] w_slot;
    logic            w_fwd_cover;

    // Walk oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        w_fwd_found = 1'b0;
        w_fwd_data  = '0;
        w_fwd_be    = '0;
        w_slot      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_slot = w_head_idx + IDXW'(i);
            if ((ptr_t'(i) < w_count) && (r_addr[w_slot] == ld_addr)) begin
                w_fwd_found = 1'b1;
                w_fwd_data  = r_data[w_slot];
                w_fwd_be    = r_be[w_slot];
            end
        end
    end

    assign w_fwd_cover    = ((ld_be & ~w_fwd_be) == 4'b0000);
    assign sb_ld_hit      = ld_valid & w_fwd_found & w_fwd_cover;
    assign sb_ld_conflict = ld_valid & w_fwd_found & ~w_fwd_cover;
    assign sb_ld_data     = w_fwd_data;

endmodule

// File: tb/tb_store_commit_buffer.sv
// Bench for store_commit_buffer: a queue model of buffered stores scores every drained
// payload and the req/full/empty flags; scenario tasks add targeted checks.
module tb_store_commit_buffer;
    localparam int DEPTH = 16;
    localparam int IDXW  = 4;
    localparam int W     = 66;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsq_sb_valid;
    logic [29:0] lsq_sb_addr;
    logic [31:0] lsq_sb_data;
    logic [3:0]  lsq_sb_be;
    logic        sb_full;
    logic        rob_ret_store;
    logic        rob_flush;
    logic        sb_dc_req;
    logic [29:0] sb_dc_addr;
    logic [31:0] sb_dc_data;
    logic [3:0]  sb_dc_be;
    logic        dc_sb_ack;
    logic        ld_valid;
    logic [29:0] ld_addr;
    logic [3:0]  ld_be;
    logic        sb_ld_hit;
    logic [31:0] sb_ld_data;
    logic        sb_ld_conflict;
    logic        sb_empty;

    always #5 clk = ~clk;

    store_commit_buffer #(.DEPTH(DEPTH), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst),
        .lsq_sb_valid(lsq_sb_valid), .lsq_sb_addr(lsq_sb_addr),
        .lsq_sb_data(lsq_sb_data), .lsq_sb_be(lsq_sb_be), .sb_full(sb_full),
        .rob_ret_store(rob_ret_store), .rob_flush(rob_flush),
        .sb_dc_req(sb_dc_req), .sb_dc_addr(sb_dc_addr), .sb_dc_data(sb_dc_data),
        .sb_dc_be(sb_dc_be), .dc_sb_ack(dc_sb_ack),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be),
        .sb_ld_hit(sb_ld_hit), .sb_ld_data(sb_ld_data),
        .sb_ld_conflict(sb_ld_conflict), .sb_empty(sb_empty)
    );

    // Model: every buffered store in program order; the first m_ncmt are committed.
    logic [W-1:0] exp_q[$];
    int           m_ncmt;
    int           n_checks;
    int           n_pass;
    bit           chk_en;

    task automatic idle_inputs();
        lsq_sb_valid  = 1'b0;
        lsq_sb_addr   = '0;
        lsq_sb_data   = '0;
        lsq_sb_be     = '0;
        rob_ret_store = 1'b0;
        rob_flush     = 1'b0;
        dc_sb_ack     = 1'b0;
        ld_valid      = 1'b0;
        ld_addr       = '0;
        ld_be         = '0;
    endtask

    // One clock: score outputs against the model, then advance the model in
    // ack, commit, flush, push order.
    task automatic tick();
        int           size0;
        int           ncmt0;
        logic         ack_ok;
        logic [W-1:0] e;
        #1;
        size0  = exp_q.size();
        ncmt0  = m_ncmt;
        ack_ok = dc_sb_ack && (ncmt0 > 0);
        if (chk_en) begin
            n_checks++;
            if (sb_dc_req !== 1'(ncmt0 > 0))
                $display("FAIL sb_req: got %b want %b", sb_dc_req, (ncmt0 > 0));
            else n_pass++;
            n_checks++;
            if (sb_full !== 1'(size0 == DEPTH))
                $display("FAIL sb_full: got %b want %b", sb_full, (size0 == DEPTH));
            else n_pass++;
            n_checks++;
            if (sb_empty !== 1'(size0 == 0))
                $display("FAIL sb_empty: got %b want %b", sb_empty, (size0 == 0));
            else n_pass++;
            if (ack_ok) begin
                e = exp_q[0];
                n_checks++;
                if ({sb_dc_addr, sb_dc_data, sb_dc_be} !== e)
                    $display("FAIL drain_payload: got %h/%h/%h want %h/%h/%h",
                             sb_dc_addr, sb_dc_data, sb_dc_be, e[65:36], e[35:4], e[3:0]);
                else n_pass++;
            end
        end
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_ncmt = 0;
        end else begin
            if (ack_ok) begin
                void'(exp_q.pop_front());
                m_ncmt--;
            end
            if (rob_ret_store && (size0 > ncmt0)) m_ncmt++;
            if (rob_flush) begin
                while (exp_q.size() > m_ncmt) void'(exp_q.pop_back());
            end else if (lsq_sb_valid && (size0 < DEPTH)) begin
                exp_q.push_back({lsq_sb_addr, lsq_sb_data, lsq_sb_be});
            end
        end
        @(negedge clk);
    endtask

    task automatic push_st(input logic [29:0] a, input logic [31:0] d, input logic [3:0] b);
        lsq_sb_valid = 1'b1;
        lsq_sb_addr  = a;
        lsq_sb_data  = d;
        lsq_sb_be    = b;
        tick();
        lsq_sb_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        ld_valid = 1'b1;
        ld_addr  = 30'h100;
        ld_be    = 4'hF;
        #1;
        n_checks++; if (sb_full !== 1'b0) $display("FAIL reset_full: got %b want 0", sb_full); else n_pass++;
        n_checks++; if (sb_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", sb_empty); else n_pass++;
        n_checks++; if (sb_dc_req !== 1'b0) $display("FAIL reset_req: got %b want 0", sb_dc_req); else n_pass++;
        n_checks++; if (sb_ld_hit !== 1'b0) $display("FAIL reset_hit: got %b want 0", sb_ld_hit); else n_pass++;
        n_checks++; if (sb_ld_conflict !== 1'b0) $display("FAIL reset_conflict: got %b want 0", sb_ld_conflict); else n_pass++;
        ld_valid = 1'b0;
    endtask

    task automatic test_drain_order();
        do_reset();
        push_st(30'h100, 32'h11111111, 4'hF);
        push_st(30'h104, 32'h22222222, 4'hF);
        push_st(30'h108, 32'h33333333, 4'hF);
        tick();
        #1;
        n_checks++; if (sb_dc_req !== 1'b0) $display("FAIL uncommitted_req: got %b want 0", sb_dc_req); else n_pass++;
        n_checks++; if (sb_empty !== 1'b0) $display("FAIL three_empty: got %b want 0", sb_empty); else n_pass++;
        rob_ret_store = 1'b1;
        dc_sb_ack     = 1'b1;
        tick();
        tick();
        rob_ret_store = 1'b0;
        tick();
        dc_sb_ack = 1'b0;
        #1;
        n_checks++; if (sb_dc_req !== 1'b0) $display("FAIL after_b_req: got %b want 0", sb_dc_req); else n_pass++;
        n_checks++; if (sb_empty !== 1'b0) $display("FAIL c_left_empty: got %b want 0", sb_empty); else n_pass++;
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 5; i++) push_st(30'($urandom), $urandom, 4'($urandom_range(1, 15)));
        rob_ret_store = 1'b1;
        dc_sb_ack     = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) push_st(30'h500 + 30'(i), $urandom, 4'($urandom_range(1, 15)));
        #1;
        n_checks++; if (sb_full !== 1'b1) $display("FAIL full_16: got %b want 1", sb_full); else n_pass++;
        lsq_sb_valid = 1'b1;
        lsq_sb_addr  = 30'h5FF;
        lsq_sb_data  = 32'hDEADBEEF;
        lsq_sb_be    = 4'hF;
        tick();
        rob_ret_store = 1'b1;
        tick();
        rob_ret_store = 1'b0;
        dc_sb_ack     = 1'b1;
        tick();
        dc_sb_ack = 1'b0;
        #1;
        n_checks++; if (sb_full !== 1'b0) $display("FAIL full_release: got %b want 0", sb_full); else n_pass++;
        tick();
        lsq_sb_valid = 1'b0;
        #1;
        n_checks++; if (sb_full !== 1'b1) $display("FAIL held_push_accept: got %b want 1", sb_full); else n_pass++;
        rob_ret_store = 1'b1;
        dc_sb_ack     = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) tick();
        idle_inputs();
        #1;
        n_checks++; if (sb_empty !== 1'b1) $display("FAIL wrap_empty: got %b want 1", sb_empty); else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++) push_st(30'h300 + 30'(i), 32'hA0 + 32'(i), 4'hF);
        rob_ret_store = 1'b1;
        tick();
        rob_ret_store = 1'b0;
        rob_flush     = 1'b1;
        lsq_sb_valid  = 1'b1;
        lsq_sb_addr   = 30'h3FF;
        lsq_sb_data   = 32'h0BAD0BAD;
        lsq_sb_be     = 4'hF;
        tick();
        idle_inputs();
        #1;
        n_checks++; if (sb_dc_req !== 1'b1) $display("FAIL flush_req: got %b want 1", sb_dc_req); else n_pass++;
        n_checks++; if (sb_empty !== 1'b0) $display("FAIL flush_empty: got %b want 0", sb_empty); else n_pass++;
        dc_sb_ack = 1'b1;
        tick();
        dc_sb_ack = 1'b0;
        #1;
        n_checks++; if (sb_empty !== 1'b1) $display("FAIL flush_drained_empty: got %b want 1", sb_empty); else n_pass++;
        // Commit applied before flush in the same cycle keeps that entry.
        push_st(30'h320, 32'h5555AAAA, 4'h3);
        push_st(30'h324, 32'h6666BBBB, 4'hC);
        rob_ret_store = 1'b1;
        rob_flush     = 1'b1;
        tick();
        idle_inputs();
        dc_sb_ack = 1'b1;
        tick();
        dc_sb_ack = 1'b0;
        #1;
        n_checks++; if (sb_empty !== 1'b1) $display("FAIL commit_flush_empty: got %b want 1", sb_empty); else n_pass++;
    endtask

    task automatic test_forward();
        do_reset();
        push_st(30'h200, 32'h0000BEEF, 4'b0011);
        push_st(30'h200, 32'hCAFE0000, 4'b1100);
        push_st(30'h210, 32'h12345678, 4'hF);
        ld_valid = 1'b1; ld_addr = 30'h200; ld_be = 4'b1100;
        #1;
        n_checks++; if (sb_ld_hit !== 1'b1) $display("FAIL fwd_hit: got %b want 1", sb_ld_hit); else n_pass++;
        n_checks++; if (sb_ld_data !== 32'hCAFE0000) $display("FAIL fwd_data: got %h want cafe0000", sb_ld_data); else n_pass++;
        ld_be = 4'b0011;
        #1;
        n_checks++; if ({sb_ld_hit, sb_ld_conflict} !== 2'b01) $display("FAIL fwd_conflict: got %b want 01", {sb_ld_hit, sb_ld_conflict}); else n_pass++;
        ld_addr = 30'h204; ld_be = 4'hF;
        #1;
        n_checks++; if ({sb_ld_hit, sb_ld_conflict} !== 2'b00) $display("FAIL fwd_miss: got %b want 00", {sb_ld_hit, sb_ld_conflict}); else n_pass++;
        idle_inputs();
        ld_addr = 30'h200; ld_be = 4'b1100;
        tick();
        #1;
        n_checks++; if ({sb_ld_hit, sb_ld_conflict} !== 2'b00) $display("FAIL fwd_ld_invalid: got %b want 00", {sb_ld_hit, sb_ld_conflict}); else n_pass++;
        rob_ret_store = 1'b1;
        repeat (3) tick();
        rob_ret_store = 1'b0;
        dc_sb_ack     = 1'b1;
        tick();
        tick();
        ld_valid = 1'b1; ld_addr = 30'h210; ld_be = 4'b0001;
        #1;
        n_checks++; if (sb_ld_hit !== 1'b1) $display("FAIL fwd_acked_hit: got %b want 1", sb_ld_hit); else n_pass++;
        n_checks++; if (sb_ld_data !== 32'h12345678) $display("FAIL fwd_acked_data: got %h want 12345678", sb_ld_data); else n_pass++;
        tick();
        idle_inputs();
        #1;
        n_checks++; if (sb_empty !== 1'b1) $display("FAIL fwd_done_empty: got %b want 1", sb_empty); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_st(30'h400, 32'hFEEDF00D, 4'hF);
        push_st(30'h404, 32'h0A0B0C0D, 4'h5);
        rob_ret_store = 1'b1;
        tick();
        rob_ret_store = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            n_checks++;
            if ({sb_dc_req, sb_dc_addr, sb_dc_data, sb_dc_be} !== {1'b1, 30'h400, 32'hFEEDF00D, 4'hF})
                $display("FAIL stall_stable: got %b/%h/%h/%h want 1/400/feedf00d/f",
                         sb_dc_req, sb_dc_addr, sb_dc_data, sb_dc_be);
            else n_pass++;
        end
        rob_ret_store = 1'b1;
        dc_sb_ack     = 1'b1;
        tick();
        rob_ret_store = 1'b0;
        dc_sb_ack     = 1'b0;
        #1;
        n_checks++;
        if ({sb_dc_req, sb_dc_addr, sb_dc_be} !== {1'b1, 30'h404, 4'h5})
            $display("FAIL commit_ack_same: got %b/%h/%h want 1/404/5", sb_dc_req, sb_dc_addr, sb_dc_be);
        else n_pass++;
        dc_sb_ack = 1'b1;
        tick();
        dc_sb_ack = 1'b0;
        #1;
        n_checks++; if (sb_empty !== 1'b1) $display("FAIL b2b_empty: got %b want 1", sb_empty); else n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int i = 0; i < 5; i++) push_st(30'h600 + 30'(i), $urandom, 4'hF);
        rob_ret_store = 1'b1;
        tick();
        tick();
        rob_ret_store = 1'b0;
        #1;
        n_checks++; if (sb_dc_req !== 1'b1) $display("FAIL pre_rst_req: got %b want 1", sb_dc_req); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (sb_empty !== 1'b1) $display("FAIL rst_mid_empty: got %b want 1", sb_empty); else n_pass++;
        n_checks++; if (sb_dc_req !== 1'b0) $display("FAIL rst_mid_req: got %b want 0", sb_dc_req); else n_pass++;
        n_checks++; if (sb_full !== 1'b0) $display("FAIL rst_mid_full: got %b want 0", sb_full); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_ncmt   = 0;
        chk_en   = 1'b0;
        rst      = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_drain_order();
        test_full_wrap();
        test_flush();
        test_forward();
        test_back_to_back();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
